// File: rtl/prim_clock_en_mux.sv
// prim_clock_en_mux: glitch-free N-way selector of clock-enable strobes, with drain/gap/arm switching
module prim_clock_en_mux #(
    parameter int NumSrc     = 4,
    parameter int RstSel     = 0,
    parameter int GapCycles  = 2,
    parameter int TimeoutCyc = 255,
    parameter int SelW       = $clog2(NumSrc)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumSrc-1:0] en_i,
    input  logic [SelW-1:0]   sel_i,
    input  logic              sel_valid_i,
    output logic              sel_ready_o,
    output logic              en_o,
    output logic [SelW-1:0]   cur_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    localparam int TmoW   = $clog2(TimeoutCyc + 1);
    localparam int GapW   = $clog2(GapCycles + 1);
    localparam int NumPad = 1 << SelW;
    localparam logic [1:0] StActive = 2'd0;
    localparam logic [1:0] StDrain  = 2'd1;
    localparam logic [1:0] StGap    = 2'd2;
    localparam logic [1:0] StArm    = 2'd3;
    logic [1:0]        state_q, state_d;
    logic [SelW-1:0]   cur_q, cur_d, nxt_q, nxt_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              done_q, done_d, err_q, err_d;
    logic [NumPad-1:0] en_ext;
    logic              cur_en, tmo_end, sel_bad;
    // padding lets cur_q index safely when NumSrc is not a power of two
    assign en_ext  = NumPad'(en_i);
    assign cur_en  = en_ext[cur_q];
    assign tmo_end = tmo_q == TmoW'(TimeoutCyc - 1);
    assign sel_bad = {1'b0, sel_i} >= (SelW + 1)'(NumSrc);
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            StActive: if (sel_valid_i) begin
                if (sel_bad) err_d = 1'b1;
                else if (sel_i == cur_q) done_d = 1'b1;
                else begin
                    state_d = StDrain;
                    nxt_d   = sel_i;
                    tmo_d   = '0;
                end
            end
            StDrain: if (cur_en || tmo_end) begin
                state_d = StGap;
                gap_d   = '0;
                err_d   = err_q | ~cur_en;
            end else tmo_d = tmo_q + 1'b1;
            StGap: if (gap_q == GapW'(GapCycles - 1)) begin
                state_d = StArm;
                cur_d   = nxt_q;
                tmo_d   = '0;
            end else gap_d = gap_q + 1'b1;
            default: if (cur_en || tmo_end) begin
                state_d = StActive;
                done_d  = 1'b1;
                err_d   = err_q | ~cur_en;
            end else tmo_d = tmo_q + 1'b1;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StActive;
            cur_q   <= SelW'(RstSel);
            nxt_q   <= '0;
            tmo_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign en_o        = (state_q != StGap) & cur_en;
    assign sel_ready_o = state_q == StActive;
    assign busy_o      = state_q != StActive;
    assign cur_sel_o   = cur_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule
